// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA command sequencer.
// Holds the state encoding, the opcode values and the burst-counter width helper.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;

  // Wide enough to count every burst of a full 2^32-byte transfer, plus one.
  function automatic int cnt_width(input int burst_bytes);
    return 33 - $clog2(burst_bytes);
  endfunction

endpackage

// File: rtl/dma_cmd_sequencer_burst_req_gen.sv
// One burst request channel: holds VALID/ADDR until READY, steps the address
// by one burst per handshake and counts the bursts issued.
module burst_req_gen
  import dma_seq_pkg::*;
#(
  parameter int BURST_BYTES = 128,
  parameter int CW          = 26
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          load,
  input  logic [31:0]   base,
  input  logic          en,
  input  logic          req_ready,
  output logic          req_valid,
  output logic [31:0]   req_addr,
  output logic [CW-1:0] issued
);

  logic          valid_r;
  logic [31:0]   addr_r;
  logic [CW-1:0] issued_r;

  // Request register: a raised request is held until its handshake, then dropped for a cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      valid_r  <= 1'b0;
      addr_r   <= 32'd0;
      issued_r <= '0;
    end else if (load) begin
      valid_r  <= 1'b0;
      addr_r   <= base;
      issued_r <= '0;
    end else if (valid_r) begin
      if (req_ready) begin
        valid_r  <= 1'b0;
        addr_r   <= addr_r + 32'(BURST_BYTES);
        issued_r <= issued_r + CW'(1);
      end
    end else if (en) begin
      valid_r <= 1'b1;
    end
  end

  assign req_valid = valid_r;
  assign req_addr  = addr_r;
  assign issued    = issued_r;

endmodule

// File: rtl/dma_cmd_sequencer.sv
// Turns one MMIO copy command into read/write burst requests, throttling reads
// against free buffer slots and ordering writes behind landed read data.
module dma_cmd_sequencer
  import dma_seq_pkg::*;
#(
  parameter int BURST_BYTES     = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        MMIO_VALID,
  output logic        MMIO_READY,
  input  logic [31:0] MMIO_CMD,
  input  logic [31:0] STREAM_SRC,
  input  logic [31:0] STREAM_DEST,
  input  logic [31:0] STREAM_LEN,
  output logic        RD_REQ_VALID,
  input  logic        RD_REQ_READY,
  output logic [31:0] RD_REQ_ADDR,
  input  logic        RD_DONE,
  output logic        WR_REQ_VALID,
  input  logic        WR_REQ_READY,
  output logic [31:0] WR_REQ_ADDR,
  input  logic        WR_DONE,
  output logic        ERR,
  output logic        DONE
);

  localparam int LB = $clog2(BURST_BYTES);
  localparam int CW = cnt_width(BURST_BYTES);

  state_e        state_r, state_s;
  logic [1:0]    op_r;
  logic [31:0]   src_r, dest_r, len_r;
  logic [CW-1:0] total_r, rd_done_r, wr_done_r;
  logic [CW-1:0] rd_iss_s, wr_iss_s, wr_iss_nx_s;
  logic          err_r, done_r, ready_r;
  logic          accept_s, check_err_s, live_s;
  logic          rd_en_s, wr_en_s;
  logic          rd_ok_s, wr_ok_s, pulse_bad_s;
  logic          unused_cmd_s;

  assign unused_cmd_s = ^MMIO_CMD[31:2];
  assign accept_s     = MMIO_VALID && ready_r;
  assign live_s       = (state_r == ST_RUN) || (state_r == ST_DRAIN);

  // The end-address test uses a 33-bit sum so that ending exactly at 2^32 is legal.
  assign check_err_s = (op_r != OP_NOP && op_r != OP_COPY)
                    || (|src_r[LB-1:0]) || (|dest_r[LB-1:0]) || (|len_r[LB-1:0])
                    || (({1'b0, src_r} + {1'b0, len_r}) > 33'h1_0000_0000)
                    || (({1'b0, dest_r} + {1'b0, len_r}) > 33'h1_0000_0000);

  assign rd_en_s = (state_r == ST_RUN) && (rd_iss_s < total_r)
                && ((rd_iss_s - wr_done_r) < CW'(MAX_OUTSTANDING));
  assign wr_en_s = (state_r == ST_RUN) && (wr_iss_s < rd_done_r);

  assign rd_ok_s     = RD_DONE && live_s && (rd_done_r < rd_iss_s);
  assign wr_ok_s     = WR_DONE && live_s && (wr_done_r < wr_iss_s);
  assign pulse_bad_s = (RD_DONE && live_s && !rd_ok_s) || (WR_DONE && live_s && !wr_ok_s);
  assign wr_iss_nx_s = wr_iss_s + CW'(WR_REQ_VALID && WR_REQ_READY);

  burst_req_gen #(.BURST_BYTES(BURST_BYTES), .CW(CW)) u_rd_gen (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load      (accept_s),
    .base      (STREAM_SRC),
    .en        (rd_en_s),
    .req_ready (RD_REQ_READY),
    .req_valid (RD_REQ_VALID),
    .req_addr  (RD_REQ_ADDR),
    .issued    (rd_iss_s)
  );

  burst_req_gen #(.BURST_BYTES(BURST_BYTES), .CW(CW)) u_wr_gen (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load      (accept_s),
    .base      (STREAM_DEST),
    .en        (wr_en_s),
    .req_ready (WR_REQ_READY),
    .req_valid (WR_REQ_VALID),
    .req_addr  (WR_REQ_ADDR),
    .issued    (wr_iss_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_CHECK;
        else          state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (check_err_s || op_r == OP_NOP || len_r == 32'd0) state_s = ST_FIN;
        else                                                 state_s = ST_RUN;
      end
      ST_RUN: begin
        if (wr_iss_nx_s == total_r) state_s = ST_DRAIN;
        else                        state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (wr_done_r == total_r) state_s = ST_FIN;
        else                      state_s = ST_DRAIN;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, command latch, completion counters and registered status outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'd0;
      src_r     <= 32'd0;
      dest_r    <= 32'd0;
      len_r     <= 32'd0;
      total_r   <= '0;
      rd_done_r <= '0;
      wr_done_r <= '0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= (state_r == ST_IDLE) && !accept_s;
      done_r  <= (state_r == ST_FIN);
      if (accept_s) begin
        op_r      <= MMIO_CMD[1:0];
        src_r     <= STREAM_SRC;
        dest_r    <= STREAM_DEST;
        len_r     <= STREAM_LEN;
        total_r   <= '0;
        rd_done_r <= '0;
        wr_done_r <= '0;
        err_r     <= 1'b0;
      end else begin
        if (state_r == ST_CHECK) begin
          total_r <= {1'b0, len_r[31:LB]};
          if (check_err_s) err_r <= 1'b1;
        end
        if (rd_ok_s)     rd_done_r <= rd_done_r + CW'(1);
        if (wr_ok_s)     wr_done_r <= wr_done_r + CW'(1);
        if (pulse_bad_s) err_r     <= 1'b1;
      end
    end
  end

  assign MMIO_READY = ready_r;
  assign ERR        = err_r;
  assign DONE       = done_r;

endmodule
